// File: rtl/led_pkg.sv
// led_pkg: mode encodings, bounce direction type and init-pattern helper for the LED engine
package led_pkg;
  localparam logic [1:0] MODE_ROR    = 2'd0;
  localparam logic [1:0] MODE_ROL    = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_BIN    = 2'd3;
  typedef enum logic {DIR_DOWN, DIR_UP} dir_e;
  // Active-low start pattern of a mode, 16 bits wide; callers keep the low led_w bits.
  function automatic logic [15:0] init_light(input logic [1:0] mode, input int led_w);
    return (mode == MODE_ROL) ? 16'hFFFE :
           (mode == MODE_BIN) ? 16'hFFFF : ~(16'd1 << (led_w - 1));
  endfunction
endpackage

// File: rtl/led_pattern_gen_if.sv
// led_pattern_gen_if: switch inputs and LED/strobe outputs of the pattern engine
interface led_pattern_gen_if #(parameter int LED_W = 4);
  logic [1:0]       mode;
  logic [1:0]       speed;
  logic             pause;
  logic [LED_W-1:0] light;
  logic             step_pulse;
  modport master (output mode, speed, pause, input light, step_pulse);
  modport slave  (input mode, speed, pause, output light, step_pulse);
endinterface

// File: rtl/led_tick_gen.sv
// led_tick_gen: prescaler producing one tick per pattern step, period shortened by 2**speed
module led_tick_gen #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int STEP_HZ = 2
) (
  input  logic       clk50m,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [1:0] speed,
  output logic       tick
);
  localparam int PERIOD = CLK_HZ / STEP_HZ;
  localparam int CNT_W  = $clog2(PERIOD);
  logic [CNT_W-1:0] cnt_q, cnt_d, pmax;
  assign pmax = CNT_W'((PERIOD >> speed) - 1);
  // >= lets a count stranded above a freshly shortened period wrap at once
  assign tick = en && !clr && cnt_q >= pmax;
  // Count advances only when enabled; a clear wins and suppresses the tick
  always_comb cnt_d = clr ? '0 : !en ? cnt_q : tick ? '0 : cnt_q + 1'b1;
  // Prescaler register
  always_ff @(posedge clk50m or negedge rst)
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: runtime-selectable LED pattern engine with speed, pause and step strobe
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int LED_W   = 4,
  parameter int CLK_HZ  = 50_000_000,
  parameter int STEP_HZ = 2
) (
  input logic               clk50m,
  input logic               rst,
  led_pattern_gen_if.slave  bus
);
  localparam int PW = $clog2(LED_W);
  logic [1:0]       mode_m_q, mode_s_q, speed_m_q, speed_s_q, mode_q;
  logic             pause_m_q, pause_s_q, step_q, tick, mode_chg;
  logic [LED_W-1:0] light_q, light_d, cnt_q, cnt_d;
  logic [PW-1:0]    pos_q, pos_d;
  dir_e             dir_q, dir_d;
  assign mode_chg       = mode_s_q != mode_q;
  assign bus.light      = light_q;
  assign bus.step_pulse = step_q;
  led_tick_gen #(.CLK_HZ(CLK_HZ), .STEP_HZ(STEP_HZ)) u_tick (
    .clk50m (clk50m),
    .rst    (rst),
    .clr    (mode_chg),
    .en     (!pause_s_q),
    .speed  (speed_s_q),
    .tick   (tick)
  );
  // Two-flop synchronisers for the asynchronous board switches
  always_ff @(posedge clk50m or negedge rst)
    if (!rst) begin
      {mode_m_q, mode_s_q, speed_m_q, speed_s_q} <= '0;
      {pause_m_q, pause_s_q} <= '0;
    end else begin
      {mode_m_q, mode_s_q}   <= {bus.mode, mode_m_q};
      {speed_m_q, speed_s_q} <= {bus.speed, speed_m_q};
      {pause_m_q, pause_s_q} <= {bus.pause, pause_m_q};
    end
  // Next pattern: a mode change reloads the init state, otherwise a tick advances one step
  always_comb begin
    light_d = light_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    if (mode_chg) begin
      light_d = LED_W'(init_light(mode_s_q, LED_W));
      pos_d   = PW'(LED_W - 1);
      dir_d   = DIR_DOWN;
      cnt_d   = '0;
    end else if (tick) begin
      case (mode_q)
        MODE_ROR: light_d = {light_q[0], light_q[LED_W-1:1]};
        MODE_ROL: light_d = {light_q[LED_W-2:0], light_q[LED_W-1]};
        MODE_BOUNCE: begin
          if (dir_q == DIR_DOWN) begin
            pos_d = pos_q == '0 ? PW'(1) : pos_q - 1'b1;
            dir_d = pos_q == '0 ? DIR_UP : DIR_DOWN;
          end else begin
            pos_d = pos_q == PW'(LED_W - 1) ? PW'(LED_W - 2) : pos_q + 1'b1;
            dir_d = pos_q == PW'(LED_W - 1) ? DIR_DOWN : DIR_UP;
          end
          light_d = ~(LED_W'(1) << pos_d);
        end
        default: begin
          cnt_d   = cnt_q + 1'b1;
          light_d = ~cnt_d;
        end
      endcase
    end
  end
  // Mode, pattern, bounce and strobe registers
  always_ff @(posedge clk50m or negedge rst)
    if (!rst) begin
      mode_q  <= MODE_ROR;
      light_q <= LED_W'(init_light(MODE_ROR, LED_W));
      pos_q   <= PW'(LED_W - 1);
      dir_q   <= DIR_DOWN;
      cnt_q   <= '0;
      step_q  <= 1'b0;
    end else begin
      mode_q  <= mode_s_q;
      light_q <= light_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      step_q  <= tick;
    end
endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: randomized bench against a step-index reference model of the LED engine
module tb_led_pattern_gen;
  localparam int W = 4;
  localparam int PERIOD = 16 / 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  led_pattern_gen_if #(.LED_W(W)) bus ();
  led_pattern_gen #(.LED_W(W), .CLK_HZ(16), .STEP_HZ(2)) dut (
    .clk50m (clk),
    .rst    (rst_n),
    .bus    (bus)
  );
  int total = 0;
  int bad = 0;
  logic [1:0] ms1, ms2, ss1, ss2, mm;
  logic ps1, ps2, mstep;
  int mc, mk;
  // Reference: mk counts steps since the current mode was loaded; mc counts cycles within a period
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {ms1, ms2, ss1, ss2, mm} <= '0;
      {ps1, ps2, mstep} <= '0;
      mc <= 0;
      mk <= 0;
    end else begin
      ms1 <= bus.mode; ms2 <= ms1;
      ss1 <= bus.speed; ss2 <= ss1;
      ps1 <= bus.pause; ps2 <= ps1;
      if (ms2 != mm) begin
        mm <= ms2; mc <= 0; mk <= 0; mstep <= 1'b0;
      end else if (!ps2 && mc >= (PERIOD >> ss2) - 1) begin
        mc <= 0; mk <= mk + 1; mstep <= 1'b1;
      end else begin
        mc <= ps2 ? mc : mc + 1; mstep <= 1'b0;
      end
    end
  function automatic logic [W-1:0] exp_light(input logic [1:0] m, input int k);
    int p;
    logic [W-1:0] c;
    case (m)
      2'd0: p = W - 1 - (k % W);
      2'd1: p = k % W;
      2'd2: begin
        p = k % (2 * W - 2);
        p = p < W ? W - 1 - p : p - (W - 1);
      end
      default: begin
        c = W'(k % (1 << W));
        return ~c;
      end
    endcase
    return ~(W'(1) << p);
  endfunction
  task automatic test_reset();
    rst_n = 1'b0;
    bus.mode = 2'd0; bus.speed = 2'd0; bus.pause = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (bus.light !== 4'b0111) begin bad++; $display("FAIL reset_light got=%b want=0111", bus.light); end
    total++;
    if (bus.step_pulse !== 1'b0) begin bad++; $display("FAIL reset_step got=%b want=0", bus.step_pulse); end
  endtask
  task automatic test_rotate();
    logic [W-1:0] q[$];
    logic [W-1:0] want[4] = '{4'b1011, 4'b1101, 4'b1110, 4'b0111};
    rst_n = 1'b1;
    repeat (34) begin
      @(negedge clk);
      total++;
      if (bus.light !== exp_light(mm, mk) || bus.step_pulse !== mstep) begin
        bad++; $display("FAIL rotate got=%b/%b want=%b/%b", bus.light, bus.step_pulse, exp_light(mm, mk), mstep);
      end
      if (bus.step_pulse) q.push_back(bus.light);
    end
    total++;
    if (q.size() != 4) begin bad++; $display("FAIL rotate_steps got=%0d want=4", q.size()); end
    for (int i = 0; i < 4 && i < q.size(); i++) begin
      total++;
      if (q[i] !== want[i]) begin bad++; $display("FAIL rotate_seq%0d got=%b want=%b", i, q[i], want[i]); end
    end
  endtask
  task automatic test_bounce();
    logic [W-1:0] q[$];
    logic [W-1:0] want[7] = '{4'b1011, 4'b1101, 4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1011};
    rst_n = 1'b0;
    bus.mode = 2'd2;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (64) begin
      @(negedge clk);
      total++;
      if (bus.light !== exp_light(mm, mk) || bus.step_pulse !== mstep) begin
        bad++; $display("FAIL bounce got=%b/%b want=%b/%b", bus.light, bus.step_pulse, exp_light(mm, mk), mstep);
      end
      if (bus.step_pulse) q.push_back(bus.light);
    end
    for (int i = 0; i < 7; i++) begin
      total++;
      if (i >= q.size() || q[i] !== want[i]) begin
        bad++; $display("FAIL bounce_seq%0d got=%b want=%b", i, i < q.size() ? q[i] : 'x, want[i]);
      end
    end
  endtask
  task automatic test_binary();
    logic [W-1:0] q[$];
    bus.mode = 2'd3; bus.speed = 2'd3;
    repeat (24) begin
      @(negedge clk);
      total++;
      if (bus.light !== exp_light(mm, mk) || bus.step_pulse !== mstep) begin
        bad++; $display("FAIL binary got=%b/%b want=%b/%b", bus.light, bus.step_pulse, exp_light(mm, mk), mstep);
      end
      if (bus.step_pulse) q.push_back(bus.light);
    end
    total++;
    if (q.size() < 16 || q[0] !== 4'b1110 || q[15] !== 4'b1111) begin
      bad++; $display("FAIL binary_wrap got=%0d steps first=%b sixteenth=%b want=1110/1111", q.size(),
                      q.size() > 0 ? q[0] : 'x, q.size() > 15 ? q[15] : 'x);
    end
  endtask
  task automatic test_pause();
    logic [W-1:0] held;
    bus.mode = 2'd0; bus.speed = 2'd0;
    repeat (12) @(negedge clk);
    bus.pause = 1'b1;
    repeat (3) @(negedge clk);
    held = bus.light;
    repeat (20) begin
      @(negedge clk);
      total++;
      if (bus.light !== held || bus.step_pulse !== 1'b0 || bus.light !== exp_light(mm, mk)) begin
        bad++; $display("FAIL pause got=%b/%b want=%b/0", bus.light, bus.step_pulse, held);
      end
    end
    bus.pause = 1'b0;
    repeat (20) begin
      @(negedge clk);
      total++;
      if (bus.light !== exp_light(mm, mk) || bus.step_pulse !== mstep) begin
        bad++; $display("FAIL pause_resume got=%b/%b want=%b/%b", bus.light, bus.step_pulse, exp_light(mm, mk), mstep);
      end
    end
  endtask
  task automatic test_speed_change();
    int n = 0;
    while (mc != 3 && n < 20) begin @(negedge clk); n++; end
    total++;
    if (mc != 3) begin bad++; $display("FAIL speed_wait got=%0d want=3", mc); end
    bus.speed = 2'd3;
    repeat (2) @(negedge clk);
    total++;
    if (bus.step_pulse !== 1'b0) begin bad++; $display("FAIL speed_pre got=%b want=0", bus.step_pulse); end
    @(negedge clk);
    total++;
    if (bus.step_pulse !== 1'b1) begin bad++; $display("FAIL speed_wrap got=%b want=1", bus.step_pulse); end
    @(negedge clk);
    total++;
    if (bus.step_pulse !== 1'b1) begin bad++; $display("FAIL speed_fast got=%b want=1", bus.step_pulse); end
    bus.speed = 2'd0;
  endtask
  task automatic test_mode_tick();
    int n = 0;
    repeat (4) @(negedge clk);
    while (mc != 5 && n < 20) begin @(negedge clk); n++; end
    total++;
    if (mc != 5) begin bad++; $display("FAIL mode_wait got=%0d want=5", mc); end
    bus.mode = 2'd1;
    repeat (3) @(negedge clk);
    total++;
    if (bus.light !== 4'b1110 || bus.step_pulse !== 1'b0) begin
      bad++; $display("FAIL mode_tick got=%b/%b want=1110/0", bus.light, bus.step_pulse);
    end
    repeat (10) begin
      @(negedge clk);
      total++;
      if (bus.light !== exp_light(mm, mk) || bus.step_pulse !== mstep) begin
        bad++; $display("FAIL mode_after got=%b/%b want=%b/%b", bus.light, bus.step_pulse, exp_light(mm, mk), mstep);
      end
    end
  endtask
  task automatic test_async_reset();
    int n = 0;
    bus.mode = 2'd2; bus.speed = 2'd3;
    repeat (3) @(negedge clk);
    while (!(mm == 2'd2 && mk % 6 == 5) && n < 40) begin @(negedge clk); n++; end
    total++;
    if (!(mm == 2'd2 && mk % 6 == 5)) begin bad++; $display("FAIL upsweep_wait got=%0d want=5", mk % 6); end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (bus.light !== 4'b0111 || bus.step_pulse !== 1'b0) begin
      bad++; $display("FAIL async_reset got=%b/%b want=0111/0", bus.light, bus.step_pulse);
    end
    bus.mode = 2'd0; bus.speed = 2'd0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      total++;
      if (bus.light !== exp_light(mm, mk) || bus.step_pulse !== mstep) begin
        bad++; $display("FAIL reset_restart got=%b/%b want=%b/%b", bus.light, bus.step_pulse, exp_light(mm, mk), mstep);
      end
    end
  endtask
  task automatic test_random();
    repeat (1500) begin
      @(negedge clk);
      total++;
      if (bus.light !== exp_light(mm, mk) || bus.step_pulse !== mstep) begin
        bad++; $display("FAIL random m=%0d got=%b/%b want=%b/%b", mm, bus.light, bus.step_pulse, exp_light(mm, mk), mstep);
      end
      if (mm != 2'd3) begin
        total++;
        if ($countones(~bus.light) != 1) begin bad++; $display("FAIL one_hot got=%b want=one zero", bus.light); end
      end
      if ($urandom_range(19) == 0) bus.mode = 2'($urandom_range(3));
      if ($urandom_range(19) == 0) bus.speed = 2'($urandom_range(3));
      if ($urandom_range(14) == 0) bus.pause = ~bus.pause;
    end
    bus.pause = 1'b0;
  endtask
  initial begin
    test_reset();
    test_rotate();
    test_bounce();
    test_binary();
    test_pause();
    test_speed_change();
    test_mode_tick();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
